mem_ftch_sched: RTL

Scheduler that shares the single-ported instruction/data memory between the fetch stage and the memory stage. It arbitrates fetch reads against data loads/stores, tracks outstanding reads in order, and returns fetch results on the mem_ftch valid/packet channel. It also returns load data to the memory stage and silently drops fetch results squashed by a redirect. It sits between the fetch/memory pipeline stages and the memory macro.

---
 rtl/mem_ftch_pkg.sv | 9 +
 rtl/mem_ftch_sched_pkg.sv | 19 +
 rtl/mem_ftch_trk_fifo.sv | 78 +++++++
 rtl/mem_ftch_sched.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mem_ftch_pkg.sv
// Fetch-result packet shared between the scheduler and the fetch stage.
package mem_ftch_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } mem_ftch_pkt_t;

endpackage

// File: rtl/mem_ftch_sched_pkg.sv
// Types and default sizing for the fetch/data memory scheduler.
package mem_ftch_sched_pkg;

   typedef enum logic {
      SRC_FTCH = 1'b0,
      SRC_DATA = 1'b1
   } src_e;

   // One outstanding read: who asked, whether a redirect killed it, and its pc.
   typedef struct packed {
      src_e        src;
      logic        squashed;
      logic [31:0] pc;
   } trk_entry_t;

   localparam int unsigned DEF_MAX_OUTST  = 4;
   localparam int unsigned DEF_MAX_STREAK = 3;

endpackage

// File: rtl/mem_ftch_trk_fifo.sv
// In-order tracker of outstanding memory reads. Besides push/pop it can mark
// every stored entry of a given source as squashed in one cycle; the head seen
// by the consumer already includes a squash requested in the same cycle.
module mem_ftch_trk_fifo
   import mem_ftch_sched_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_MAX_OUTST
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     i_push,
   input  trk_entry_t               i_push_entry,
   input  logic                     i_pop,
   input  logic                     i_squash,
   input  src_e                     i_squash_src,
   output trk_entry_t               o_head,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   trk_entry_t        r_mem [DEPTH];
   logic [PW-1:0]     r_rd_ptr;
   logic [PW-1:0]     r_wr_ptr;
   logic [CW-1:0]     r_count;
   logic              w_full;
   logic              w_push;
   logic              w_pop;

   assign o_empty = (r_count == '0);
   assign w_full  = (r_count == CW'(DEPTH));
   assign w_push  = i_push & ~w_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_count = r_count;

   // Head entry, with a same-cycle squash folded in so a popped entry is dropped too.
   always_comb begin
      o_head = r_mem[r_rd_ptr];
      if (i_squash && (r_mem[r_rd_ptr].src == i_squash_src)) begin
         o_head.squashed = 1'b1;
      end
   end

   // Storage, pointers and occupancy; DEPTH is a power of two so pointers wrap freely.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (i_squash) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (r_mem[i].src == i_squash_src) begin
                  r_mem[i].squashed <= 1'b1;
               end
            end
         end
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_entry;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/mem_ftch_sched.sv
// Shares the single-ported memory between fetch and the memory stage.
// Data wins by default; a bounded streak counter guarantees fetch progress.
// Reads are tracked in order so responses can be routed back by source, and
// fetches killed by a redirect are dropped when their data comes back.
module mem_ftch_sched
   import mem_ftch_sched_pkg::*;
   import mem_ftch_pkg::*;
#(
   parameter int unsigned MAX_OUTST  = DEF_MAX_OUTST,
   parameter int unsigned MAX_STREAK = DEF_MAX_STREAK
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          ftch_req_vld,
   input  logic [31:0]   ftch_req_pc,
   output logic          ftch_req_rdy,
   input  logic          ftch_flush,
   input  logic          dmem_req_vld,
   input  logic          dmem_req_we,
   input  logic [31:0]   dmem_req_addr,
   input  logic [31:0]   dmem_req_wdata,
   output logic          dmem_req_rdy,
   output logic          mem_req_vld,
   output logic          mem_req_we,
   output logic [31:0]   mem_req_addr,
   output logic [31:0]   mem_req_wdata,
   input  logic          mem_rsp_vld,
   input  logic [31:0]   mem_rsp_rdata,
   output logic          mem_ftch_vld,
   output mem_ftch_pkt_t mem_ftch_pkt,
   output logic          dmem_rsp_vld,
   output logic [31:0]   dmem_rsp_rdata,
   output logic          sched_err
);

   localparam int unsigned CW = $clog2(MAX_OUTST) + 1;
   localparam int unsigned SW = $clog2(MAX_STREAK + 1);

   logic [SW-1:0]  r_streak;
   logic           r_ftch_vld;
   mem_ftch_pkt_t  r_ftch_pkt;
   logic           r_drsp_vld;
   logic [31:0]    r_drsp_rdata;
   logic           r_sched_err;

   logic [CW-1:0]  w_trk_cnt;
   logic           w_trk_empty;
   trk_entry_t     w_head;
   trk_entry_t     w_push_entry;
   logic           w_push;
   logic           w_pop;
   logic           w_rd_room;
   logic           w_d_ok;
   logic           w_f_ok;
   logic           w_streak_hit;
   logic           w_f_gnt;
   logic           w_d_gnt;

   // Room is judged on the registered count only: a pop this cycle frees nothing yet.
   // Grants are qualified with resetn so every output reads 0 while reset is held.
   assign w_rd_room    = (w_trk_cnt < CW'(MAX_OUTST));
   assign w_d_ok       = resetn & dmem_req_vld & (dmem_req_we | w_rd_room);
   assign w_f_ok       = resetn & ftch_req_vld & ~ftch_flush & w_rd_room;
   assign w_streak_hit = (r_streak == SW'(MAX_STREAK));

   // A load blocked by a full tracker also blocks fetch (w_rd_room is shared),
   // so fetch can never overtake it.
   assign w_f_gnt = w_f_ok & (~w_d_ok | w_streak_hit);
   assign w_d_gnt = w_d_ok & ~w_f_gnt;

   assign ftch_req_rdy  = w_f_gnt;
   assign dmem_req_rdy  = w_d_gnt;
   assign mem_req_vld   = w_f_gnt | w_d_gnt;
   assign mem_req_we    = w_d_gnt & dmem_req_we;
   assign mem_req_addr  = w_d_gnt ? dmem_req_addr : (w_f_gnt ? ftch_req_pc : 32'h0);
   assign mem_req_wdata = w_d_gnt ? dmem_req_wdata : 32'h0;

   assign w_push = w_f_gnt | (w_d_gnt & ~dmem_req_we);
   assign w_pop  = mem_rsp_vld & ~w_trk_empty;

   // Tracker entry for the read being granted this cycle.
   always_comb begin
      w_push_entry          = '0;
      w_push_entry.src      = w_f_gnt ? SRC_FTCH : SRC_DATA;
      w_push_entry.squashed = 1'b0;
      w_push_entry.pc       = w_f_gnt ? ftch_req_pc : dmem_req_addr;
   end

   mem_ftch_trk_fifo #(
      .DEPTH (MAX_OUTST)
   ) u_trk (
      .clk          (clk),
      .resetn       (resetn),
      .i_push       (w_push),
      .i_push_entry (w_push_entry),
      .i_pop        (w_pop),
      .i_squash     (ftch_flush),
      .i_squash_src (SRC_FTCH),
      .o_head       (w_head),
      .o_empty      (w_trk_empty),
      .o_count      (w_trk_cnt)
   );

   // Count data wins while fetch waits; any fetch win or idle fetch clears it.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_streak <= '0;
      end else if (!ftch_req_vld || w_f_gnt) begin
         r_streak <= '0;
      end else if (w_d_gnt && !w_streak_hit) begin
         r_streak <= r_streak + 1'b1;
      end
   end

   // Route each popped response to fetch or data; squashed fetches vanish.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_ftch_vld   <= 1'b0;
         r_ftch_pkt   <= '0;
         r_drsp_vld   <= 1'b0;
         r_drsp_rdata <= '0;
      end else begin
         r_ftch_vld <= 1'b0;
         r_drsp_vld <= 1'b0;
         if (w_pop) begin
            if (w_head.src == SRC_DATA) begin
               r_drsp_vld   <= 1'b1;
               r_drsp_rdata <= mem_rsp_rdata;
            end else if (!w_head.squashed) begin
               r_ftch_vld       <= 1'b1;
               r_ftch_pkt.pc    <= w_head.pc;
               r_ftch_pkt.instr <= mem_rsp_rdata;
            end
         end
      end
   end

   // A response with nothing outstanding is a protocol error, held until reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_sched_err <= 1'b0;
      end else if (mem_rsp_vld && w_trk_empty) begin
         r_sched_err <= 1'b1;
      end
   end

   assign mem_ftch_vld   = r_ftch_vld;
   assign mem_ftch_pkt   = r_ftch_pkt;
   assign dmem_rsp_vld   = r_drsp_vld;
   assign dmem_rsp_rdata = r_drsp_rdata;
   assign sched_err      = r_sched_err;

endmodule
